// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, digit config record and anode helper
// for the 4-digit 7-segment scan logic.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Active-low cathode patterns, bit 7 = dp (kept off).
    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;
    localparam logic [7:0] SEG_L = 8'hC7;
    localparam logic [7:0] SEG_R = 8'hAF;
    localparam logic [7:0] SEG_U = 8'hC1;

    typedef struct packed {
        logic [7:0] seg;
        logic       en;
        logic       blink;
    } digit_cfg_t;

    localparam digit_cfg_t CFG_RESET = '{
        seg:   SEG_BLANK,
        en:    1'b0,
        blink: 1'b0
    };

    // One-hot-low anode select; digit 0 is the rightmost anode.
    function automatic logic [3:0] digit_to_an(input logic [1:0] d);
        logic [3:0] an;
        unique case (d)
            2'd0:    an = 4'b1110;
            2'd1:    an = 4'b1101;
            2'd2:    an = 4'b1011;
            default: an = 4'b0111;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/seg_scan_scheduler_tick_gen.sv
// tick_gen: free-running divider, one-cycle tick every DIV clocks.
// The tick is high on the last count, as the counter wraps to zero.
module tick_gen #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    // Count 0..DIV-1 and wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/seg_scan_scheduler.sv
// seg_scan_scheduler: blanked 4-digit 7-segment scan with shadow
// digit configs committed atomically at the frame boundary.
import seg_pkg::*;

module seg_scan_scheduler #(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter int unsigned BLINK_DIV    = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [1:0] wr_digit,
    input  logic [7:0] wr_seg,
    input  logic       wr_en,
    input  logic       wr_blink,
    input  logic       commit,
    output logic       commit_pending,
    output logic       frame_start,
    output logic [3:0] an,
    output logic [7:0] seg
);

    localparam int unsigned SW = $clog2(SCAN_DIV);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BLANK_LAST = SW'(BLANK_CYCLES - 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [0:0]    state;
    logic [SW-1:0] slot_cnt;
    logic [1:0]    digit;

    logic blink_tick;
    logic blink_phase;

    digit_cfg_t shadow [4];
    digit_cfg_t active [4];
    digit_cfg_t cur;

    logic boundary;
    logic wr_fire;
    logic show;

    tick_gen #(
        .DIV(BLINK_DIV)
    ) u_blink_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (blink_tick)
    );

    // First cycle of the digit-0 blank: where commits are applied.
    assign boundary = (state == ST_BLANK) && (digit == 2'd0)
                   && (slot_cnt == '0);

    // Stall writes on the copy cycle so the copy sees a stable shadow.
    assign wr_ready = !(boundary && commit_pending);
    assign wr_fire  = wr_valid && wr_ready;

    assign cur  = active[digit];
    assign show = (state == ST_DRIVE) && cur.en
               && !(cur.blink && blink_phase);

    // Slot sequencer: blank lead-in, then drive, then next digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_BLANK;
            slot_cnt <= '0;
            digit    <= 2'd0;
        end else if (slot_cnt == SLOT_LAST) begin
            state    <= ST_BLANK;
            slot_cnt <= '0;
            digit    <= digit + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + SW'(1);
            if (slot_cnt == BLANK_LAST) begin
                state <= ST_DRIVE;
            end
        end
    end

    // Blink phase flips on each divider tick, unrelated to scanning.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_phase <= 1'b0;
        end else if (blink_tick) begin
            blink_phase <= ~blink_phase;
        end
    end

    // Shadow registers, written only through the handshake port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= CFG_RESET;
            end
        end else if (wr_fire) begin
            shadow[wr_digit] <= '{
                seg:   wr_seg,
                en:    wr_en,
                blink: wr_blink
            };
        end
    end

    // Commit arming and frame-aligned copy of all four digits.
    // A commit seen on the boundary cycle arms the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_pending <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                active[i] <= CFG_RESET;
            end
        end else if (boundary) begin
            if (commit_pending) begin
                active <= shadow;
            end
            commit_pending <= commit;
        end else if (commit) begin
            commit_pending <= 1'b1;
        end
    end

    // Registered pins: an and seg always change together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an          <= AN_OFF;
            seg         <= SEG_BLANK;
            frame_start <= 1'b0;
        end else begin
            an          <= show ? digit_to_an(digit) : AN_OFF;
            seg         <= show ? cur.seg : SEG_BLANK;
            frame_start <= boundary;
        end
    end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// tb_seg_scan_scheduler: scoreboard bench with a frame-arithmetic
// reference model and randomized shadow writes and commits.
module tb_seg_scan_scheduler;

    localparam int SD  = 10;
    localparam int BC  = 2;
    localparam int BD  = 40;
    localparam int FRM = 4 * SD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [1:0] wr_digit = 2'd0;
    logic [7:0] wr_seg = 8'hFF;
    logic       wr_en = 1'b0;
    logic       wr_blink = 1'b0;
    logic       commit = 1'b0;
    logic       commit_pending;
    logic       frame_start;
    logic [3:0] an;
    logic [7:0] seg;

    seg_scan_scheduler #(
        .SCAN_DIV    (SD),
        .BLANK_CYCLES(BC),
        .BLINK_DIV   (BD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_digit      (wr_digit),
        .wr_seg        (wr_seg),
        .wr_en         (wr_en),
        .wr_blink      (wr_blink),
        .commit        (commit),
        .commit_pending(commit_pending),
        .frame_start   (frame_start),
        .an            (an),
        .seg           (seg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] seg;
        bit         en;
        bit         blink;
    } cfg_t;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
        logic       fs;
        logic       pend;
        logic       rdy;
    } exp_t;

    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    cfg_t sh [4];
    cfg_t ac [4];
    int   tcyc;
    bit   pend;
    exp_t q [$];

    int vectors = 0;
    int miscompares = 0;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            sh[i] = '{8'hFF, 1'b0, 1'b0};
            ac[i] = '{8'hFF, 1'b0, 1'b0};
        end
        tcyc = 0;
        pend = 1'b0;
        q.delete();
    endtask

    // Reference: position in the frame decides digit and blank/drive.
    always @(posedge clk) begin
        if (rst_n) begin : model
            int   p, d, s, ph;
            bit   bnd, rdy_now;
            exp_t e;
            p   = tcyc % FRM;
            d   = p / SD;
            s   = p % SD;
            ph  = (tcyc / BD) % 2;
            bnd = (p == 0);
            rdy_now = !(bnd && pend);
            e.an  = 4'b1111;
            e.seg = 8'hFF;
            if (s >= BC && ac[d].en && !(ac[d].blink && ph == 1)) begin
                e.an  = an_tab[d];
                e.seg = ac[d].seg;
            end
            e.fs = bnd;
            if (wr_valid && rdy_now)
                sh[wr_digit] = '{wr_seg, wr_en, wr_blink};
            if (bnd) begin
                if (pend)
                    for (int i = 0; i < 4; i++) ac[i] = sh[i];
                pend = commit;
            end else if (commit) begin
                pend = 1'b1;
            end
            tcyc++;
            e.pend = pend;
            e.rdy  = !((tcyc % FRM == 0) && pend);
            q.push_back(e);
        end
    end

    // Monitor: pop one expectation per cycle and compare all outputs.
    always @(negedge clk) begin
        if (rst_n && q.size() > 0) begin : mon
            exp_t e, g;
            e = q.pop_front();
            g = {an, seg, frame_start, commit_pending, wr_ready};
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL scan t=%0t an=%b want %b seg=%h want %h fs=%b want %b pend=%b want %b rdy=%b want %b",
                         $time, g.an, e.an, g.seg, e.seg, g.fs, e.fs,
                         g.pend, e.pend, g.rdy, e.rdy);
            end
        end
    end

    task automatic check1(input string name, input logic [15:0] got,
                          input logic [15:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] d, input logic [7:0] s,
                            input bit en, input bit bl);
        int n;
        n = 0;
        wr_valid = 1'b1;
        wr_digit = d;
        wr_seg   = s;
        wr_en    = en;
        wr_blink = bl;
        @(negedge clk);
        while (!wr_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL wr_timeout got stalled want ready");
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        @(posedge clk);
        #1;
        commit = 1'b0;
    endtask

    task automatic wait_pos(input int pos);
        int n;
        n = 0;
        while ((tcyc % FRM) != pos && n < 2 * FRM) begin
            @(posedge clk);
            #1;
            n++;
        end
        if ((tcyc % FRM) != pos) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_pos got %0d want %0d", tcyc % FRM, pos);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #23;
        check1("rst_an",   {12'd0, an}, 16'h000F);
        check1("rst_seg",  {8'd0, seg}, 16'h00FF);
        check1("rst_ctl",  {13'd0, wr_ready, commit_pending, frame_start},
               16'h0004);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(1);

        // Idle frames: dark display, frame_start every 40 cycles.
        cycles(3 * FRM);

        // Digits 0 and 2 lit, digit 1 dark.
        do_write(2'd0, 8'hC0, 1'b1, 1'b0);
        do_write(2'd2, 8'hF9, 1'b1, 1'b0);
        do_commit();
        cycles(2 * FRM);

        // Shadow-only write, then commit.
        do_write(2'd0, 8'hA4, 1'b1, 1'b0);
        cycles(3 * FRM);
        do_commit();
        cycles(2 * FRM);

        // Blinking digit 3.
        do_write(2'd3, 8'h99, 1'b1, 1'b1);
        do_commit();
        cycles(4 * FRM);

        // Write held across the copy cycle is stalled one cycle.
        do_commit();
        wait_pos(0);
        do_write(2'd1, 8'hB0, 1'b1, 1'b0);
        cycles(FRM);
        do_commit();
        cycles(2 * FRM);

        // Random writes, commits and write+commit collisions.
        for (int i = 0; i < 120; i++) begin
            int r;
            r = int'($urandom_range(0, 3));
            if (r == 0) begin
                do_write(2'($urandom_range(0, 3)), 8'($urandom),
                         1'($urandom), 1'($urandom));
            end else if (r == 1) begin
                do_commit();
            end else if (r == 2) begin
                commit = 1'b1;
                do_write(2'($urandom_range(0, 3)), 8'($urandom),
                         1'b1, 1'($urandom));
                commit = 1'b0;
            end else begin
                cycles(int'($urandom_range(1, 15)));
            end
        end
        cycles(2 * FRM);

        // Asynchronous reset in the middle of digit 2's drive slot.
        do_write(2'd2, 8'h92, 1'b1, 1'b0);
        do_commit();
        cycles(2 * FRM);
        wait_pos(24);
        do_commit();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check1("async_an",   {12'd0, an}, 16'h000F);
        check1("async_seg",  {8'd0, seg}, 16'h00FF);
        check1("async_pend", {15'd0, commit_pending}, 16'h0000);
        cycles(3);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(1);
        do_commit();
        cycles(3 * FRM);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
